// File: rtl/skew_reorg_pkg.sv
// Shared types and helpers for the skew/deskew stream re-organiser.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package skew_reorg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic MODE_SKEW   = 1'b0;
    localparam logic MODE_DESKEW = 1'b1;

    // Number of advances between a lane entering and appearing on dout.
    // SKEW staggers lane i by i; DESKEW undoes that stagger.
    function automatic int unsigned lane_delay(input int unsigned lane,
                                               input logic        mode,
                                               input int unsigned lanes);
        if (mode == MODE_DESKEW) begin
            return lanes - lane;
        end
        return lane + 1;
    endfunction

endpackage

// File: rtl/skew_lane_delay.sv
// Per-lane shift register with valid shadow and runtime tap select.
// Latency: sel+1 advances from in_* to out_*.
// Backpressure: shifts only when advance=1; otherwise every stage holds.
module skew_lane_delay #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 4,
    localparam int SEL_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat
);

    logic [DEPTH-1:0]      vld_q;
    logic [DEPTH-1:0]      vld_d;
    logic [DATA_WIDTH-1:0] dat_q [DEPTH];
    logic [DATA_WIDTH-1:0] dat_d [DEPTH];

    // Shift one stage per advance; bubbles enter with zero data.
    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < DEPTH; k++) begin
            dat_d[k] = dat_q[k];
        end
        if (advance) begin
            vld_d    = {vld_q[DEPTH-2:0], in_vld};
            dat_d[0] = in_vld ? in_dat : '0;
            for (int k = 1; k < DEPTH; k++) begin
                dat_d[k] = dat_q[k-1];
            end
        end
    end

    // Stage registers; reset clears both data and valid shadows.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    // Tap the selected stage; invalid slots always present zero.
    always_comb begin
        out_vld = vld_q[sel];
        out_dat = out_vld ? dat_q[sel] : '0;
    end

endmodule

// File: rtl/skew_reorg_stream.sv
// Skews or deskews a LANES-wide vector stream with an automatic end-of-stream drain.
// Latency: lane i appears after lane_delay(i) advances; drain adds LANES-1 bubbles.
// Backpressure: in_ready drops for the LANES-1 drain cycles; no advance = all outputs hold.
module skew_reorg_stream
    import skew_reorg_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*LANES-1:0] din,
    output logic [DATA_WIDTH*LANES-1:0] dout,
    output logic [LANES-1:0]            out_valid,
    output logic                        out_last
);

    localparam int CNT_W = $clog2(LANES) + 1;
    localparam int SEL_W = $clog2(LANES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             out_last_q, out_last_d;
    logic             accept;
    logic             advance;

    // Handshake, FSM next state, drain countdown and end-of-stream flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        out_last_d = 1'b0;
        in_ready   = (state_q != DRAIN);
        accept     = in_valid & in_ready;
        advance    = accept | (state_q == DRAIN);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d = mode;
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(LANES - 1);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(LANES - 1);
                end
            end
            DRAIN: begin
                // The bubble that empties the longest lane also flags the last element.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = IDLE;
                    out_last_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= MODE_SKEW;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [SEL_W-1:0]      lane_sel;
        logic                  lane_vld;
        logic [DATA_WIDTH-1:0] lane_dat;

        assign lane_sel = SEL_W'(lane_delay(g, mode_q, LANES) - 1);

        skew_lane_delay #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LANES)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .advance (advance),
            .in_vld  (accept),
            .in_dat  (din[g*DATA_WIDTH +: DATA_WIDTH]),
            .sel     (lane_sel),
            .out_vld (lane_vld),
            .out_dat (lane_dat)
        );

        assign dout[g*DATA_WIDTH +: DATA_WIDTH] = lane_dat;
        assign out_valid[g]                     = lane_vld;
    end

endmodule

// File: tb/tb_skew_reorg_stream.sv
// Self-checking bench for skew_reorg_stream with a history-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_skew_reorg_stream;

    localparam int DW = 20;
    localparam int L  = 4;
    localparam int VW = DW * L;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [VW-1:0] din = '0;
    logic          in_ready;
    logic [VW-1:0] dout;
    logic [L-1:0]  out_valid;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    // Reference model: every advance appends one slot (beat or bubble) to a
    // history; lane i at advance k shows slot k-delay(i)+1 of that history.
    logic          hv[$];
    logic          hl[$];
    logic [VW-1:0] hd[$];
    int            drain_left;
    bit            in_stream;
    logic          cur_mode;
    logic [VW-1:0] exp_dout;
    logic [L-1:0]  exp_vld;
    int            rdy_low;
    int            last_seen;

    logic [VW-1:0] tab_sk_d [5];
    logic [L-1:0]  tab_sk_v [5];
    logic [VW-1:0] tab_de_d [5];
    logic [L-1:0]  tab_de_v [5];
    logic [VW-1:0] vec_a, vec_b;

    skew_reorg_stream #(.DATA_WIDTH(DW), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .din       (din),
        .dout      (dout),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic int ref_delay(input int i, input logic m);
        return m ? (L - i) : (i + 1);
    endfunction

    function automatic logic [VW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        logic [VW-1:0] v;
        v = '0;
        v[0*DW +: DW] = DW'(a0);
        v[1*DW +: DW] = DW'(a1);
        v[2*DW +: DW] = DW'(a2);
        v[3*DW +: DW] = DW'(a3);
        return v;
    endfunction

    task automatic model_clear();
        hv.delete();
        hl.delete();
        hd.delete();
        drain_left = 0;
        in_stream  = 0;
        cur_mode   = 1'b0;
        exp_dout   = '0;
        exp_vld    = '0;
    endtask

    // One clock of stimulus with scoreboard comparison of every output.
    task automatic step(input logic v, input logic l, input logic md, input logic [VW-1:0] d);
        bit            acc, adv;
        logic          exp_last;
        int            idx;
        logic [VW-1:0] e;
        mode     = md;
        in_valid = v;
        in_last  = l;
        din      = d;
        rst      = 1'b0;
        checks++;
        if (in_ready !== (drain_left == 0)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready, (drain_left == 0));
        end
        if (in_ready === 1'b0) rdy_low++;
        acc = v && (drain_left == 0);
        adv = acc || (drain_left > 0);
        if (acc) begin
            if (!in_stream) begin
                cur_mode  = md;
                in_stream = 1;
            end
            hv.push_back(1'b1);
            hl.push_back(l);
            hd.push_back(d);
            if (l) begin
                drain_left = L - 1;
                in_stream  = 0;
            end
        end else if (drain_left > 0) begin
            hv.push_back(1'b0);
            hl.push_back(1'b0);
            hd.push_back('0);
            drain_left--;
        end
        @(posedge clk);
        #1;
        exp_last = 1'b0;
        if (adv) begin
            exp_dout = '0;
            exp_vld  = '0;
            for (int i = 0; i < L; i++) begin
                idx = hv.size() - ref_delay(i, cur_mode);
                if (idx >= 0 && hv[idx]) begin
                    e = hd[idx];
                    exp_dout[i*DW +: DW] = e[i*DW +: DW];
                    exp_vld[i] = 1'b1;
                end
            end
            idx = hv.size() - L;
            if (idx >= 0) exp_last = hv[idx] & hl[idx];
        end
        if (out_last === 1'b1) last_seen++;
        checks++;
        if (dout !== exp_dout) begin
            errors++;
            $display("FAIL dout: got %h want %h", dout, exp_dout);
        end
        checks++;
        if (out_valid !== exp_vld) begin
            errors++;
            $display("FAIL out_valid: got %b want %b", out_valid, exp_vld);
        end
        checks++;
        if (out_last !== exp_last) begin
            errors++;
            $display("FAIL out_last: got %b want %b", out_last, exp_last);
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        din      = '0;
        mode     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        checks++;
        if (dout !== '0 || out_valid !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: dout=%h out_valid=%b out_last=%b in_ready=%b want 0/0/0/1",
                     dout, out_valid, out_last, in_ready);
        end
    endtask

    // Two-beat stream {A, B(last)} with optional idle gap, checked against literal tables.
    task automatic run_pair(input int gap, input logic m0, input logic m1, input bit desk, input string name);
        logic [VW-1:0] wd;
        logic [L-1:0]  wv;
        rdy_low = 0;
        for (int r = 0; r < 5; r++) begin
            if (r == 0) begin
                step(1'b1, 1'b0, m0, vec_a);
            end else if (r == 1) begin
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, m1, '0);
                step(1'b1, 1'b1, m1, vec_b);
            end else begin
                step(1'b0, 1'b0, m1, '0);
            end
            wd = desk ? tab_de_d[r] : tab_sk_d[r];
            wv = desk ? tab_de_v[r] : tab_sk_v[r];
            checks++;
            if (dout !== wd || out_valid !== wv || out_last !== (r == 4)) begin
                errors++;
                $display("FAIL %s adv%0d: dout=%h vld=%b last=%b want %h %b %b",
                         name, r + 1, dout, out_valid, out_last, wd, wv, (r == 4));
            end
        end
        checks++;
        if (rdy_low != 3) begin
            errors++;
            $display("FAIL %s ready_low_cycles: got %0d want 3", name, rdy_low);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_skew();
        run_pair(0, 1'b0, 1'b0, 1'b0, "skew");
    endtask

    task automatic test_deskew();
        run_pair(0, 1'b1, 1'b1, 1'b1, "deskew");
    endtask

    task automatic test_stall();
        run_pair(2, 1'b0, 1'b0, 1'b0, "stall");
    endtask

    task automatic test_mode_change();
        run_pair(0, 1'b0, 1'b1, 1'b0, "mode_ignored");
        run_pair(0, 1'b1, 1'b1, 1'b1, "mode_next");
    endtask

    task automatic test_reset_mid_drain();
        logic [VW-1:0] x;
        int            seen0;
        step(1'b1, 1'b0, 1'b0, vec_a);
        step(1'b1, 1'b1, 1'b0, vec_b);
        seen0 = last_seen;
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (last_seen != seen0) begin
            errors++;
            $display("FAIL reset_drain_no_last: got %0d pulses want 0", last_seen - seen0);
        end
        x = pk($urandom_range(1, 1000), $urandom_range(1, 1000),
               $urandom_range(1, 1000), $urandom_range(1, 1000));
        step(1'b1, 1'b1, 1'b0, x);
        checks++;
        if (dout[0 +: DW] !== x[0 +: DW] || out_valid !== 4'b0001) begin
            errors++;
            $display("FAIL single_adv1: lane0=%h vld=%b want %h 0001", dout[0 +: DW], out_valid, x[0 +: DW]);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (dout[3*DW +: DW] !== x[3*DW +: DW] || out_valid !== 4'b1000 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_adv4: lane3=%h vld=%b last=%b want %h 1000 1",
                     dout[3*DW +: DW], out_valid, out_last, x[3*DW +: DW]);
        end
    endtask

    task automatic test_random();
        int len;
        last_seen = 0;
        for (int s = 0; s < 100; s++) begin
            len = $urandom_range(1, 16);
            for (int b = 0; b < len; b++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    step(1'b0, 1'($urandom), 1'($urandom), VW'({$urandom, $urandom, $urandom}));
                end
                step(1'b1, (b == len - 1), 1'($urandom), VW'({$urandom, $urandom, $urandom}));
            end
            while (drain_left > 0) begin
                step(1'($urandom), 1'($urandom), 1'($urandom), VW'({$urandom, $urandom, $urandom}));
            end
        end
        checks++;
        if (last_seen != 100) begin
            errors++;
            $display("FAIL random_out_last_count: got %0d want 100", last_seen);
        end
    endtask

    initial begin
        vec_a = pk(1, 2, 3, 4);
        vec_b = pk(5, 6, 7, 8);
        tab_sk_d[0] = pk(1, 0, 0, 0); tab_sk_v[0] = 4'b0001;
        tab_sk_d[1] = pk(5, 2, 0, 0); tab_sk_v[1] = 4'b0011;
        tab_sk_d[2] = pk(0, 6, 3, 0); tab_sk_v[2] = 4'b0110;
        tab_sk_d[3] = pk(0, 0, 7, 4); tab_sk_v[3] = 4'b1100;
        tab_sk_d[4] = pk(0, 0, 0, 8); tab_sk_v[4] = 4'b1000;
        tab_de_d[0] = pk(0, 0, 0, 4); tab_de_v[0] = 4'b1000;
        tab_de_d[1] = pk(0, 0, 3, 8); tab_de_v[1] = 4'b1100;
        tab_de_d[2] = pk(0, 2, 7, 0); tab_de_v[2] = 4'b0110;
        tab_de_d[3] = pk(1, 6, 0, 0); tab_de_v[3] = 4'b0011;
        tab_de_d[4] = pk(5, 0, 0, 0); tab_de_v[4] = 4'b0001;
        model_clear();
        rdy_low   = 0;
        last_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_skew();
        test_deskew();
        test_stall();
        test_mode_change();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
